// File: rtl/multi_pulse_gen_if.sv
// rtl/multi_pulse_gen_if.sv - register write bus feeding the multi-channel pulse generator
interface multi_pulse_gen_if #(
  parameter int ADDR_W = 32
);
  logic              wr;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (output wr, output waddr, output wdata);
  modport slave  (input  wr, input  waddr, input  wdata);
endinterface

// File: rtl/multi_pulse_gen.sv
// rtl/multi_pulse_gen.sv - NUM_CH register-triggered pulse burst generators with global STOP
// Optional per-channel done strobe output is enabled by defining PULSE_GEN_DONE_EN.
module multi_pulse_gen #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  multi_pulse_gen_if.slave    bus,
  output logic [NUM_CH-1:0]   pulse,
  output logic [NUM_CH-1:0]   busy
`ifdef PULSE_GEN_DONE_EN
  ,
  output logic [NUM_CH-1:0]   done
`endif
);

  // One counter serves both the high length and the 16-bit gap.
  localparam int CW = (CNT_W > 16) ? CNT_W : 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [ADDR_W-1:0] STOP_ADDR = ADDR_W'(BASE_ADDR + 32'(8 * NUM_CH));

  logic              wr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wr_q    <= bus.wr;
      waddr_q <= bus.waddr;
      wdata_q <= bus.wdata;
    end
  end

  logic stop_wr;
  assign stop_wr = wr_q && (waddr_q == STOP_ADDR);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [ADDR_W-1:0] TRIG_ADDR = ADDR_W'(BASE_ADDR + 32'(8 * i));
    localparam logic [ADDR_W-1:0] CFG_ADDR  = ADDR_W'(BASE_ADDR + 32'(8 * i + 4));

    logic trig_hit;
    logic cfg_hit;
    logic stop_hit;

    assign trig_hit = wr_q && (waddr_q == TRIG_ADDR);
    assign cfg_hit  = wr_q && (waddr_q == CFG_ADDR);
    assign stop_hit = stop_wr && wdata_q[i];

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] len_a;
    logic [15:0]      gap_a;
    logic [15:0]      rep_left;
    logic [15:0]      gap_sh;
    logic [15:0]      rep_sh;
    logic             pulse_r;
    logic             busy_r;
`ifdef PULSE_GEN_DONE_EN
    logic             done_r;
`endif

    // Shadow CFG is only sampled at trigger so a running burst is never disturbed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gap_sh <= '0;
        rep_sh <= '0;
      end else if (cfg_hit) begin
        gap_sh <= wdata_q[15:0];
        rep_sh <= wdata_q[31:16];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        len_a    <= '0;
        gap_a    <= '0;
        rep_left <= '0;
        pulse_r  <= 1'b0;
        busy_r   <= 1'b0;
`ifdef PULSE_GEN_DONE_EN
        done_r   <= 1'b0;
`endif
      end else begin
`ifdef PULSE_GEN_DONE_EN
        done_r <= 1'b0;
`endif
        if (stop_hit) begin
          state   <= ST_IDLE;
          cnt     <= '0;
          pulse_r <= 1'b0;
          busy_r  <= 1'b0;
        end else if (trig_hit) begin
          state    <= ST_HIGH;
          len_a    <= wdata_q[CNT_W-1:0];
          cnt      <= CW'(wdata_q[CNT_W-1:0]);
          gap_a    <= gap_sh;
          rep_left <= rep_sh;
          pulse_r  <= 1'b1;
          busy_r   <= 1'b1;
        end else begin
          case (state)
            ST_HIGH: begin
              if (cnt != '0) begin
                cnt <= cnt - CW'(1);
              end else if (rep_left == 16'd0) begin
                state   <= ST_IDLE;
                pulse_r <= 1'b0;
                busy_r  <= 1'b0;
`ifdef PULSE_GEN_DONE_EN
                done_r  <= 1'b1;
`endif
              end else begin
                state    <= ST_GAP;
                cnt      <= CW'(gap_a);
                rep_left <= rep_left - 16'd1;
                pulse_r  <= 1'b0;
              end
            end
            ST_GAP: begin
              if (cnt != '0) begin
                cnt <= cnt - CW'(1);
              end else begin
                state   <= ST_HIGH;
                cnt     <= CW'(len_a);
                pulse_r <= 1'b1;
              end
            end
            default: begin
              state <= ST_IDLE;
            end
          endcase
        end
      end
    end

    assign pulse[i] = pulse_r;
    assign busy[i]  = busy_r;
`ifdef PULSE_GEN_DONE_EN
    assign done[i]  = done_r;
`endif
  end

endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb/tb_multi_pulse_gen.sv - scoreboard bench for multi_pulse_gen against a timeline reference model
module tb_multi_pulse_gen;
  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 32;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] busy;
`ifdef PULSE_GEN_DONE_EN
  logic [NUM_CH-1:0] done_w;
`endif

  multi_pulse_gen_if #(.ADDR_W(ADDR_W)) bus ();

  multi_pulse_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .pulse(pulse),
    .busy(busy)
`ifdef PULSE_GEN_DONE_EN
    ,
    .done(done_w)
`endif
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // A burst is a timeline: starts at cycle s, period LEN+GAP+2, REP+1 high phases.
  typedef struct {
    longint s;
    longint len;
    longint gap;
    longint rep;
    bit     act;
  } rec_t;

  rec_t        hist [NUM_CH][$];
  logic [15:0] sh_gap [NUM_CH];
  logic [15:0] sh_rep [NUM_CH];

  typedef struct {
    longint            c;
    logic [NUM_CH-1:0] p;
    logic [NUM_CH-1:0] b;
    logic [NUM_CH-1:0] d;
  } exp_t;

  exp_t sbq[$];

  function automatic void model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      hist[ch].delete();
      sh_gap[ch] = '0;
      sh_rep[ch] = '0;
    end
  endfunction

  function automatic void model_write(input longint t, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    int ch;
    rec_t r;
    off = a - BASE;
    if (off == 32'(8 * NUM_CH)) begin
      for (int k = 0; k < NUM_CH; k++)
        if (d[k]) begin
          r = '{s: t + 2, len: 0, gap: 0, rep: 0, act: 1'b0};
          hist[k].push_back(r);
        end
    end else if (off < 32'(8 * NUM_CH) && (off % 4) == 0) begin
      ch = int'(off / 8);
      if ((off % 8) == 0) begin
        r = '{s: t + 2, len: longint'(d), gap: longint'(sh_gap[ch]),
              rep: longint'(sh_rep[ch]), act: 1'b1};
        hist[ch].push_back(r);
      end else begin
        sh_gap[ch] = d[15:0];
        sh_rep[ch] = d[31:16];
      end
    end
  endfunction

  function automatic void exp_ch(input int ch, input longint c,
                                 output logic p, output logic b, output logic d);
    int idx;
    rec_t r;
    longint per, off, k, ph;
    p = 1'b0; b = 1'b0; d = 1'b0;
    idx = -1;
    for (int i = 0; i < hist[ch].size(); i++)
      if (hist[ch][i].s <= c) idx = i;
    if (idx >= 0 && hist[ch][idx].act) begin
      r   = hist[ch][idx];
      per = r.len + r.gap + 2;
      off = c - r.s;
      k   = off / per;
      ph  = off % per;
      if (k < r.rep || (k == r.rep && ph <= r.len)) begin
        b = 1'b1;
        p = (ph <= r.len);
      end
      d = (off == r.rep * per + r.len + 1);
    end
  endfunction

  // Predictor: expected outputs for the current cycle go into the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    logic pp, bb, dd;
    #2;
    if (chk_en) begin
      e.c = cyc;
      e.p = '0; e.b = '0; e.d = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        exp_ch(ch, cyc, pp, bb, dd);
        e.p[ch] = pp;
        e.b[ch] = bb;
        e.d[ch] = dd;
      end
      sbq.push_back(e);
    end
  end

  // Monitor: DUT outputs sampled mid-cycle, compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty cycle %0d: no expectation queued", cyc);
      end else begin
        e = sbq.pop_front();
        n_tests++;
        if (pulse !== e.p) begin
          n_fail++;
          $display("FAIL pulse cycle %0d: got %b expected %b", e.c, pulse, e.p);
        end
        n_tests++;
        if (busy !== e.b) begin
          n_fail++;
          $display("FAIL busy cycle %0d: got %b expected %b", e.c, busy, e.b);
        end
`ifdef PULSE_GEN_DONE_EN
        n_tests++;
        if (done_w !== e.d) begin
          n_fail++;
          $display("FAIL done cycle %0d: got %b expected %b", e.c, done_w, e.d);
        end
`endif
      end
    end
  end

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    bus.wr    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    model_write(cyc, a, d);
    @(posedge clk); #1;
    bus.wr = 1'b0;
  endtask

  task automatic trig(input int ch, input logic [31:0] len);
    wr_reg(BASE + 32'(8 * ch), len);
  endtask

  task automatic cfg(input int ch, input logic [15:0] gap, input logic [15:0] rep);
    wr_reg(BASE + 32'(8 * ch + 4), {rep, gap});
  endtask

  task automatic stop(input logic [31:0] mask);
    wr_reg(BASE + 32'(8 * NUM_CH), mask);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic zero_check(input string tag);
    n_tests++;
    if (pulse !== '0) begin
      n_fail++;
      $display("FAIL %s_pulse: got %b expected 0", tag, pulse);
    end
    n_tests++;
    if (busy !== '0) begin
      n_fail++;
      $display("FAIL %s_busy: got %b expected 0", tag, busy);
    end
  endtask

  // Called at posedge+1; asserts reset asynchronously away from the clock edge.
  task automatic mid_reset();
    chk_en = 1'b0;
    sbq.delete();
    #2 rst_n = 1'b0;
    #1 zero_check("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bad;
    int op, ch;
    bus.wr    = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 zero_check("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    cfg(0, 16'd0, 16'd0);
    trig(0, 32'd3);
    idle(10);

    cfg(1, 16'd1, 16'd2);
    trig(1, 32'd1);
    idle(20);

    trig(2, 32'd100);
    idle(8);
    stop(32'h4);
    idle(6);

    trig(0, 32'd5);
    idle(2);
    trig(0, 32'd2);
    idle(10);

    cfg(3, 16'd0, 16'd0);
    trig(3, 32'd0);
    wr_reg(BASE + 32'd2, 32'd5);
    wr_reg(BASE + 32'(8 * NUM_CH + 4), 32'hF);
    idle(5);

    cfg(0, 16'd2, 16'd3);
    cfg(1, 16'd1, 16'd5);
    trig(0, 32'd6);
    trig(1, 32'd4);
    idle(4);
    mid_reset();
    idle(30);

    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, NUM_CH - 1);
      case (op)
        0, 1, 2: trig(ch, ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 40))
                                                        : 32'($urandom_range(0, 6)));
        3, 4:    cfg(ch, 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
        5:       stop(($urandom() & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15)));
        6: begin
          case ($urandom_range(0, 3))
            0:       bad = BASE + 32'(8 * ch + 2);
            1:       bad = BASE + 32'(8 * NUM_CH + 4);
            2:       bad = BASE - 32'd8;
            default: bad = BASE + 32'(8 * NUM_CH + 8);
          endcase
          wr_reg(bad, $urandom());
        end
        default: idle($urandom_range(1, 6));
      endcase
    end
    idle(150);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
